seg7_mux_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_decode.sv | 33 +++
 rtl/seg7_mux_driver.sv | 103 ++++++++++
 tb/tb_seg7_mux_driver.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment patterns (a..g, MSB = a) and width helper for the seg7 multiplexed driver.
package seg7_pkg;

  localparam logic [6:0] SEG_0   = 7'b1111110;
  localparam logic [6:0] SEG_1   = 7'b0110000;
  localparam logic [6:0] SEG_2   = 7'b1101101;
  localparam logic [6:0] SEG_3   = 7'b1111001;
  localparam logic [6:0] SEG_4   = 7'b0110011;
  localparam logic [6:0] SEG_5   = 7'b1011011;
  localparam logic [6:0] SEG_6   = 7'b1011111;
  localparam logic [6:0] SEG_7   = 7'b1110000;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1111011;
  localparam logic [6:0] SEG_A   = 7'b1110111;
  localparam logic [6:0] SEG_B   = 7'b0011111;
  localparam logic [6:0] SEG_C   = 7'b1001110;
  localparam logic [6:0] SEG_D   = 7'b0111101;
  localparam logic [6:0] SEG_E   = 7'b1001111;
  localparam logic [6:0] SEG_F   = 7'b1000111;
  localparam logic [6:0] SEG_ERR = 7'b0000001;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Bit width needed to count 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to a..g decoder; hex_mode selects A..F glyphs, otherwise 10..15 show the error pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_ERR;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = hex_mode ? SEG_A : SEG_ERR;
      4'hB: seg = hex_mode ? SEG_B : SEG_ERR;
      4'hC: seg = hex_mode ? SEG_C : SEG_ERR;
      4'hD: seg = hex_mode ? SEG_D : SEG_ERR;
      4'hE: seg = hex_mode ? SEG_E : SEG_ERR;
      4'hF: seg = hex_mode ? SEG_F : SEG_ERR;
      default: seg = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed NUM_DIGITS 7-segment driver with registered seg_7/an outputs.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int HEX_MODE      = 0,
  parameter int AN_ACTIVE_LOW = 1,
  localparam int DIDX_W       = clog2_min1(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank,
  output logic [0:6]              seg_7,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [DIDX_W-1:0]       digit_idx,
  output logic                    frame_done
);

  localparam int PRE_W = clog2_min1(REFRESH_DIV);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PRE_W-1:0]        prescaler;
  logic [4*NUM_DIGITS-1:0] value_reg;
  logic [3:0]              nibbles [NUM_DIGITS];
  logic [3:0]              cur_nibble;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [NUM_DIGITS-1:0]   an_on;
  logic                    terminal;
  logic                    digit_last;
  logic                    zero_blank;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign nibbles[gi] = value_reg[4*gi +: 4];
    end
  endgenerate

`ifdef SEG7_LZB_EN
  // A digit goes dark when it and every more significant nibble are zero; digit 0 always shows.
  logic [NUM_DIGITS-1:0] lead_zero;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
      if (gi == 0) begin : g_first
        assign lead_zero[gi] = 1'b0;
      end else begin : g_upper
        assign lead_zero[gi] = (value_reg[4*NUM_DIGITS-1:4*gi] == '0);
      end
    end
  endgenerate
  assign zero_blank = lead_zero[digit_idx];
`else
  assign zero_blank = 1'b0;
`endif

  assign cur_nibble = nibbles[digit_idx];
  assign terminal   = (prescaler == PRE_W'(REFRESH_DIV - 1));
  assign digit_last = (digit_idx == DIDX_W'(NUM_DIGITS - 1));

  seg7_decode u_decode (
    .nibble   (cur_nibble),
    .hex_mode (HEX_MODE != 0),
    .seg      (dec_seg)
  );

  always_comb begin
    onehot            = '0;
    onehot[digit_idx] = 1'b1;
  end

  assign an_on = (AN_ACTIVE_LOW != 0) ? ~onehot : onehot;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler  <= '0;
      digit_idx  <= '0;
      value_reg  <= '0;
      frame_done <= 1'b0;
      seg_7      <= SEG_OFF;
      an         <= AN_OFF;
    end else begin
      if (terminal) begin
        prescaler <= '0;
        digit_idx <= digit_last ? '0 : digit_idx + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      frame_done <= terminal && digit_last;
      if (load) begin
        value_reg <= value;
      end
      // Outputs sample the pre-edge digit and value, hence the one-cycle lag behind digit_idx.
      seg_7 <= (blank || zero_blank) ? SEG_OFF : dec_seg;
      an    <= blank ? AN_OFF : an_on;
    end
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Self-checking bench for seg7_mux_driver: a BCD and a hex instance share stimulus and are checked against a cycle-count model.
module tb_seg7_mux_driver;

  localparam int N = 4;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst_n, load, blank;
  logic [15:0] value;
  logic [0:6]  seg_b, seg_h;
  logic [3:0]  an_b, an_h;
  logic [1:0]  idx_b, idx_h;
  logic        fd_b, fd_h;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_mux_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .HEX_MODE(0), .AN_ACTIVE_LOW(1)) u_bcd (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .blank(blank),
    .seg_7(seg_b), .an(an_b), .digit_idx(idx_b), .frame_done(fd_b)
  );

  seg7_mux_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .HEX_MODE(1), .AN_ACTIVE_LOW(1)) u_hex (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .blank(blank),
    .seg_7(seg_h), .an(an_h), .digit_idx(idx_h), .frame_done(fd_h)
  );

  // Reference model: everything derives from the number of edges since reset release.
  int          edges;
  logic [15:0] mval;
  logic [6:0]  mseg_b, mseg_h;
  logic [3:0]  man;
  logic        mfd;

  function automatic logic [6:0] ref_seg(input int n, input bit hex);
    logic [6:0] tbl [16];
    tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
            7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    if (!hex && n >= 10) return 7'b0000001;
    return tbl[n];
  endfunction

  function automatic int cur_digit(input int e);
    return (e / R) % N;
  endfunction

  function automatic int nib(input logic [15:0] v, input int d);
    return int'((v >> (4 * d)) & 16'hF);
  endfunction

  function automatic bit ref_lzb(input logic [15:0] v, input int k);
`ifdef SEG7_LZB_EN
    return (k > 0) && ((v >> (4 * k)) == 16'h0);
`else
    return (k < 0) && (v == 16'h0);
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      edges  <= 0;
      mval   <= '0;
      mseg_b <= '0;
      mseg_h <= '0;
      man    <= 4'hF;
      mfd    <= 1'b0;
    end else begin
      mseg_b <= (blank || ref_lzb(mval, cur_digit(edges))) ? 7'b0 : ref_seg(nib(mval, cur_digit(edges)), 1'b0);
      mseg_h <= (blank || ref_lzb(mval, cur_digit(edges))) ? 7'b0 : ref_seg(nib(mval, cur_digit(edges)), 1'b1);
      man    <= blank ? 4'hF : ~(4'b0001 << cur_digit(edges));
      mfd    <= ((edges + 1) % (R * N)) == 0;
      edges  <= edges + 1;
      if (load) mval <= value;
    end
  end

  task automatic test_reset();
    int pulses = 0;
    rst_n = 1'b0; load = 1'b1; value = 16'h8888; blank = 1'b0;
    repeat (3) @(negedge clk);
    load = 1'b0;
    checks += 5;
    if (seg_b !== 7'b0) begin errors++; $display("FAIL reset_seg got=%b exp=0000000", seg_b); end
    if (seg_h !== 7'b0) begin errors++; $display("FAIL reset_seg_hex got=%b exp=0000000", seg_h); end
    if (an_b !== 4'hF) begin errors++; $display("FAIL reset_an got=%b exp=1111", an_b); end
    if (idx_b !== 2'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", idx_b); end
    if (fd_b !== 1'b0) begin errors++; $display("FAIL reset_fd got=%b exp=0", fd_b); end
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks += 3;
      if (idx_b !== 2'(cur_digit(edges))) begin errors++; $display("FAIL scan_idx edge=%0d got=%0d exp=%0d", edges, idx_b, cur_digit(edges)); end
      if (idx_h !== 2'(cur_digit(edges))) begin errors++; $display("FAIL scan_idx_hex edge=%0d got=%0d exp=%0d", edges, idx_h, cur_digit(edges)); end
      if (fd_b !== mfd) begin errors++; $display("FAIL frame_done edge=%0d got=%b exp=%b", edges, fd_b, mfd); end
      if (fd_b === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 2) begin errors++; $display("FAIL frame_pulses got=%0d exp=2", pulses); end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_bcd();
    load = 1'b1; value = 16'h1234;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks += 3;
      if (seg_b !== mseg_b) begin errors++; $display("FAIL bcd_seg edge=%0d got=%b exp=%b", edges, seg_b, mseg_b); end
      if (seg_h !== mseg_h) begin errors++; $display("FAIL bcd_seg_hex edge=%0d got=%b exp=%b", edges, seg_h, mseg_h); end
      if (an_b !== man) begin errors++; $display("FAIL bcd_an edge=%0d got=%b exp=%b", edges, an_b, man); end
      if (an_b == 4'b1101) begin
        checks++;
        if (seg_b !== 7'b1111001) begin errors++; $display("FAIL bcd_digit1 got=%b exp=1111001", seg_b); end
      end
    end
    $display("test_bcd done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_hex_err();
    load = 1'b1; value = 16'h00AF;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks += 3;
      if (seg_b !== mseg_b) begin errors++; $display("FAIL err_seg edge=%0d got=%b exp=%b", edges, seg_b, mseg_b); end
      if (seg_h !== mseg_h) begin errors++; $display("FAIL hex_seg edge=%0d got=%b exp=%b", edges, seg_h, mseg_h); end
      if (an_h !== man) begin errors++; $display("FAIL hex_an edge=%0d got=%b exp=%b", edges, an_h, man); end
      if (an_b == 4'b1110) begin
        checks += 2;
        if (seg_b !== 7'b0000001) begin errors++; $display("FAIL err_digit0 got=%b exp=0000001", seg_b); end
        if (seg_h !== 7'b1000111) begin errors++; $display("FAIL hex_digit0 got=%b exp=1000111", seg_h); end
      end
    end
    $display("test_hex_err done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_blank_load();
    int guard = 0;
    while (cur_digit(edges) != 2 && guard < 64) begin @(negedge clk); guard++; end
    checks++;
    if (guard >= 64) begin errors++; $display("FAIL blank_wait got=timeout exp=digit2"); end
    blank = 1'b1;
    @(negedge clk);
    blank = 1'b0;
    checks += 4;
    if (seg_b !== 7'b0) begin errors++; $display("FAIL blank_seg got=%b exp=0000000", seg_b); end
    if (an_b !== 4'hF) begin errors++; $display("FAIL blank_an got=%b exp=1111", an_b); end
    if (idx_b !== 2'(cur_digit(edges))) begin errors++; $display("FAIL blank_idx got=%0d exp=%0d", idx_b, cur_digit(edges)); end
    if (fd_b !== mfd) begin errors++; $display("FAIL blank_fd got=%b exp=%b", fd_b, mfd); end
    guard = 0;
    while ((edges % R) != R - 1 && guard < 64) begin @(negedge clk); guard++; end
    load = 1'b1; value = 16'h9999;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    checks += 3;
    if (seg_b !== 7'b1111011) begin errors++; $display("FAIL switch_load got=%b exp=1111011", seg_b); end
    if (seg_h !== 7'b1111011) begin errors++; $display("FAIL switch_load_hex got=%b exp=1111011", seg_h); end
    if (an_b !== man) begin errors++; $display("FAIL switch_load_an got=%b exp=%b", an_b, man); end
    $display("test_blank_load done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    while (!((edges % R) == 2 && cur_digit(edges) == 3) && guard < 64) begin @(negedge clk); guard++; end
    checks++;
    if (guard >= 64) begin errors++; $display("FAIL midrst_wait got=timeout exp=pre2_digit3"); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks += 4;
    if (idx_b !== 2'd0) begin errors++; $display("FAIL midrst_idx got=%0d exp=0", idx_b); end
    if (fd_b !== 1'b0) begin errors++; $display("FAIL midrst_fd got=%b exp=0", fd_b); end
    if (seg_b !== 7'b0) begin errors++; $display("FAIL midrst_seg got=%b exp=0000000", seg_b); end
    if (an_b !== 4'hF) begin errors++; $display("FAIL midrst_an got=%b exp=1111", an_b); end
    @(negedge clk);
    checks += 2;
    if (seg_b !== 7'b1111110) begin errors++; $display("FAIL midrst_value got=%b exp=1111110", seg_b); end
    if (an_b !== 4'b1110) begin errors++; $display("FAIL midrst_an0 got=%b exp=1110", an_b); end
    $display("test_mid_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_lzb();
    logic [15:0] pats [2];
    pats = '{16'h0050, 16'h0000};
    for (int p = 0; p < 2; p++) begin
      load = 1'b1; value = pats[p];
      @(negedge clk);
      load = 1'b0;
      for (int i = 0; i < 18; i++) begin
        @(negedge clk);
        checks += 3;
        if (seg_b !== mseg_b) begin errors++; $display("FAIL lzb_seg val=%h edge=%0d got=%b exp=%b", pats[p], edges, seg_b, mseg_b); end
        if (seg_h !== mseg_h) begin errors++; $display("FAIL lzb_seg_hex val=%h edge=%0d got=%b exp=%b", pats[p], edges, seg_h, mseg_h); end
        if (an_b !== man) begin errors++; $display("FAIL lzb_an val=%h edge=%0d got=%b exp=%b", pats[p], edges, an_b, man); end
      end
    end
    $display("test_lzb done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load  = ($urandom_range(0, 3) == 0);
      value = 16'($urandom);
      blank = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      checks += 5;
      if (seg_b !== mseg_b) begin errors++; $display("FAIL rnd_seg edge=%0d got=%b exp=%b", edges, seg_b, mseg_b); end
      if (seg_h !== mseg_h) begin errors++; $display("FAIL rnd_seg_hex edge=%0d got=%b exp=%b", edges, seg_h, mseg_h); end
      if (an_b !== man) begin errors++; $display("FAIL rnd_an edge=%0d got=%b exp=%b", edges, an_b, man); end
      if (idx_b !== 2'(cur_digit(edges))) begin errors++; $display("FAIL rnd_idx edge=%0d got=%0d exp=%0d", edges, idx_b, cur_digit(edges)); end
      if (fd_h !== mfd) begin errors++; $display("FAIL rnd_fd edge=%0d got=%b exp=%b", edges, fd_h, mfd); end
    end
    load = 1'b0; blank = 1'b0;
    $display("test_random done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; blank = 1'b0; value = '0;
    test_reset();
    test_bcd();
    test_hex_err();
    test_blank_load();
    test_mid_reset();
    test_lzb();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
